// File: rtl/timer_mc_core.sv
// timer_mc_core: multi-channel timer core.
// N_CH independent CNT_W-bit counters, each with count enable, sample/hold,
// clear, compare with optional auto-reload, and a sticky compare-match IRQ.
// Optional feature macro: TIMER_PRESCALE_EN adds a shared prescaler and the
// presc_div port; without it every cycle is a count tick.
// No bus logic lives here; a separate register wrapper drives these ports.

module timer_mc_core #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 64,
    parameter int PRESC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       sample,
    input  logic [N_CH-1:0]       clear,
    input  logic [N_CH-1:0]       auto_rld,
    input  logic [N_CH-1:0]       cmp_we,
    input  logic [CNT_W-1:0]      cmp_wdata,
    input  logic [N_CH-1:0]       irq_ack,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRESC_W-1:0]    presc_div,
`endif
    output logic [N_CH*CNT_W-1:0] value,
    output logic [N_CH-1:0]       irq
);

    // Reject out-of-range configurations at elaboration time.
    if (N_CH < 1 || N_CH > 16 || CNT_W < 8 || CNT_W > 64 || PRESC_W < 1) begin : g_bad_param
        $error("timer_mc_core: parameter out of range");
    end

    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] cmp [N_CH];
    logic [CNT_W-1:0] val [N_CH];
    logic [N_CH-1:0]  match;
    logic [N_CH-1:0]  hit;
    logic             tick;

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] pcnt;

    // Tick fires when the shared prescaler reaches the divider value.
    always_comb begin
        tick = (pcnt == presc_div);
    end

    // Prescaler runs while any channel is enabled and parks at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (|en) begin
            pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
        end else begin
            pcnt <= '0;
        end
    end
`else
    // Without the prescaler every cycle is a count tick.
    always_comb begin
        tick = 1'b1;
    end
`endif

    // Compare match uses the pre-edge counter and compare value.
    always_comb begin
        match = '0;
        hit   = '0;
        for (int i = 0; i < N_CH; i++) begin
            match[i] = (cnt[i] == cmp[i]);
            hit[i]   = en[i] & tick & match[i];
        end
    end

    // Per-channel counter, compare, sample and IRQ state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
                cmp[i] <= '1;
                val[i] <= '0;
            end
            irq <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (clear[i]) begin
                    cnt[i] <= '0;
                end else if (hit[i] && auto_rld[i]) begin
                    cnt[i] <= '0;
                end else if (en[i] && tick) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end

                if (sample[i]) begin
                    val[i] <= cnt[i];
                end

                if (cmp_we[i]) begin
                    cmp[i] <= cmp_wdata;
                end

                if (hit[i]) begin
                    irq[i] <= 1'b1;
                end else if (irq_ack[i]) begin
                    irq[i] <= 1'b0;
                end
            end
        end
    end

    // Flatten the held sample values onto the output bus.
    always_comb begin
        value = '0;
        for (int i = 0; i < N_CH; i++) begin
            value[i*CNT_W +: CNT_W] = val[i];
        end
    end

endmodule

// File: tb/tb_timer_mc_core.sv
// tb_timer_mc_core: directed self-checking bench for timer_mc_core.
// A 64-bit instance covers most features; an 8-bit instance covers wrap.

module tb_timer_mc_core;

    logic         clk;
    logic         rst;
    logic [3:0]   en, sample, clear, auto_rld, cmp_we, irq_ack;
    logic [63:0]  cmp_wdata;
    logic [255:0] value;
    logic [3:0]   irq;

    logic [3:0]   en8, sample8, clear8, auto_rld8, cmp_we8, irq_ack8;
    logic [7:0]   cmp_wdata8;
    logic [31:0]  value8;
    logic [3:0]   irq8;
`ifdef TIMER_PRESCALE_EN
    logic [15:0]  presc_div;
`endif

    int checks = 0;
    int passed = 0;

    timer_mc_core #(.N_CH(4), .CNT_W(64), .PRESC_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sample(sample), .clear(clear),
        .auto_rld(auto_rld), .cmp_we(cmp_we), .cmp_wdata(cmp_wdata),
        .irq_ack(irq_ack),
`ifdef TIMER_PRESCALE_EN
        .presc_div(presc_div),
`endif
        .value(value), .irq(irq)
    );

    timer_mc_core #(.N_CH(4), .CNT_W(8), .PRESC_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .sample(sample8), .clear(clear8),
        .auto_rld(auto_rld8), .cmp_we(cmp_we8), .cmp_wdata(cmp_wdata8),
        .irq_ack(irq_ack8),
`ifdef TIMER_PRESCALE_EN
        .presc_div(presc_div),
`endif
        .value(value8), .irq(irq8)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One active edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (value !== 256'd0) $display("[TB] FAIL reset_value: got %0h expected 0", value);
        else passed++;
        checks++;
        if (irq !== 4'b0000) $display("[TB] FAIL reset_irq: got %b expected 0000", irq);
        else passed++;
        checks++;
        if (value8 !== 32'd0 || irq8 !== 4'b0000)
            $display("[TB] FAIL reset_dut8: got value %0h irq %b expected 0/0000", value8, irq8);
        else passed++;
    endtask

    task automatic test_free_run();
        en[0] = 1'b1;
        repeat (1000) step();
        sample[0] = 1'b1;
        step();
        sample[0] = 1'b0;
        en[0] = 1'b0;
        checks++;
        if (value[0 +: 64] !== 64'd1000)
            $display("[TB] FAIL free_run_value0: got %0d expected 1000", value[0 +: 64]);
        else passed++;
        checks++;
        if (value[255:64] !== 192'd0)
            $display("[TB] FAIL free_run_others: got %0h expected 0", value[255:64]);
        else passed++;
    endtask

    task automatic test_auto_reload_irq();
        cmp_wdata = 64'd9;
        cmp_we[1] = 1'b1;
        step();
        cmp_we[1] = 1'b0;
        auto_rld[1] = 1'b1;
        en[1] = 1'b1;
        repeat (9) step();
        checks++;
        if (irq[1] !== 1'b0) $display("[TB] FAIL irq_before_match: got %b expected 0", irq[1]);
        else passed++;
        step();
        checks++;
        if (irq[1] !== 1'b1) $display("[TB] FAIL irq_at_match: got %b expected 1", irq[1]);
        else passed++;
        irq_ack[1] = 1'b1;
        step();
        irq_ack[1] = 1'b0;
        checks++;
        if (irq[1] !== 1'b0) $display("[TB] FAIL irq_ack_alone: got %b expected 0", irq[1]);
        else passed++;
        repeat (8) step();
        checks++;
        if (irq[1] !== 1'b0) $display("[TB] FAIL irq_mid_period: got %b expected 0", irq[1]);
        else passed++;
        irq_ack[1] = 1'b1;
        step();
        irq_ack[1] = 1'b0;
        checks++;
        if (irq[1] !== 1'b1) $display("[TB] FAIL irq_set_wins_ack: got %b expected 1", irq[1]);
        else passed++;
        repeat (3) step();
        sample[1] = 1'b1;
        step();
        sample[1] = 1'b0;
        checks++;
        if (value[64 +: 64] !== 64'd3)
            $display("[TB] FAIL reload_period: got %0d expected 3", value[64 +: 64]);
        else passed++;
        en[1] = 1'b0;
        irq_ack[1] = 1'b1;
        step();
        irq_ack[1] = 1'b0;
    endtask

    task automatic test_wrap();
        en8[2] = 1'b1;
        repeat (255) step();
        checks++;
        if (irq8[2] !== 1'b0) $display("[TB] FAIL wrap_irq_before: got %b expected 0", irq8[2]);
        else passed++;
        step();
        checks++;
        if (irq8[2] !== 1'b1) $display("[TB] FAIL wrap_irq_match: got %b expected 1", irq8[2]);
        else passed++;
        repeat (4) step();
        en8[2] = 1'b0;
        sample8[2] = 1'b1;
        step();
        sample8[2] = 1'b0;
        checks++;
        if (value8[16 +: 8] !== 8'd4)
            $display("[TB] FAIL wrap_value: got %0d expected 4", value8[16 +: 8]);
        else passed++;
    endtask

    task automatic test_sample_clear();
        en[3] = 1'b1;
        repeat (57) step();
        sample[3] = 1'b1;
        clear[3] = 1'b1;
        step();
        sample[3] = 1'b0;
        clear[3] = 1'b0;
        checks++;
        if (value[192 +: 64] !== 64'd57)
            $display("[TB] FAIL sample_clear_old: got %0d expected 57", value[192 +: 64]);
        else passed++;
        repeat (5) step();
        sample[3] = 1'b1;
        step();
        sample[3] = 1'b0;
        en[3] = 1'b0;
        checks++;
        if (value[192 +: 64] !== 64'd5)
            $display("[TB] FAIL sample_after_clear: got %0d expected 5", value[192 +: 64]);
        else passed++;
    endtask

    task automatic test_back_to_back_reset();
        clear = 4'b1111;
        step();
        clear = 4'b0000;
        cmp_wdata = 64'd3;
        cmp_we = 4'b1111;
        step();
        cmp_we = 4'b0000;
        en = 4'b1111;
        repeat (10) step();
        checks++;
        if (irq !== 4'b1111) $display("[TB] FAIL pre_reset_irq: got %b expected 1111", irq);
        else passed++;
        sample = 4'b1111;
        cmp_we = 4'b1111;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample = 4'b0000;
        cmp_we = 4'b0000;
        checks++;
        if (value !== 256'd0) $display("[TB] FAIL mid_reset_value: got %0h expected 0", value);
        else passed++;
        checks++;
        if (irq !== 4'b0000) $display("[TB] FAIL mid_reset_irq: got %b expected 0000", irq);
        else passed++;
        repeat (10) step();
        checks++;
        if (irq !== 4'b0000) $display("[TB] FAIL post_reset_cmp: got irq %b expected 0000", irq);
        else passed++;
        sample = 4'b1111;
        step();
        sample = 4'b0000;
        en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (value[i*64 +: 64] !== 64'd10)
                $display("[TB] FAIL post_reset_count ch%0d: got %0d expected 10", i, value[i*64 +: 64]);
            else passed++;
        end
    endtask

`ifdef TIMER_PRESCALE_EN
    task automatic test_prescale();
        clear[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        presc_div = 16'd3;
        en[0] = 1'b1;
        repeat (40) step();
        sample[0] = 1'b1;
        step();
        sample[0] = 1'b0;
        checks++;
        if (value[0 +: 64] !== 64'd10)
            $display("[TB] FAIL prescale_value: got %0d expected 10", value[0 +: 64]);
        else passed++;
        en = 4'b0000;
        step();
        en[0] = 1'b1;
        repeat (3) step();
        sample[0] = 1'b1;
        step();
        sample[0] = 1'b0;
        en[0] = 1'b0;
        checks++;
        if (value[0 +: 64] !== 64'd10)
            $display("[TB] FAIL prescale_park: got %0d expected 10", value[0 +: 64]);
        else passed++;
        presc_div = 16'd0;
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        en = '0; sample = '0; clear = '0; auto_rld = '0; cmp_we = '0; irq_ack = '0;
        cmp_wdata = '0;
        en8 = '0; sample8 = '0; clear8 = '0; auto_rld8 = '0; cmp_we8 = '0; irq_ack8 = '0;
        cmp_wdata8 = '0;
`ifdef TIMER_PRESCALE_EN
        presc_div = '0;
`endif
        #1;
        test_reset();
        test_free_run();
        test_auto_reload_irq();
        test_wrap();
        test_sample_clear();
        test_back_to_back_reset();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
